// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin fetch/data arbiter in front of the memory port.
// One transaction in flight, stall watchdog, performance counters, registered outputs.
module mem_req_arbiter #(
   parameter int CORE         = 0,
   parameter int DATA_WIDTH   = 32,
   parameter int ADDRESS_BITS = 20,
   parameter int TIMEOUT      = 256
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    i_req,
   input  logic [ADDRESS_BITS-1:0] i_addr,
   output logic                    i_ack,
   output logic [DATA_WIDTH-1:0]   i_rdata,
   input  logic                    d_req,
   input  logic                    d_we,
   input  logic [ADDRESS_BITS-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0]   d_wdata,
   output logic                    d_ack,
   output logic [DATA_WIDTH-1:0]   d_rdata,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [ADDRESS_BITS-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   input  logic                    m_stall,
   output logic                    timeout_err,
   output logic [31:0]             stall_cycles,
   input  logic                    report
);

   localparam int WCW = $clog2(TIMEOUT);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic G_I = 1'b0;
   localparam logic G_D = 1'b1;

   logic [1:0]              r_state;
   logic                    r_last;
   logic                    r_gnt;
   logic                    r_we;
   logic [WCW-1:0]          r_wait_cnt;
   logic [31:0]             r_i_cnt;
   logic [31:0]             r_d_cnt;
   logic [31:0]             r_stall_cycles;
   logic                    r_timeout_err;
   logic                    r_i_ack;
   logic                    r_d_ack;
   logic [DATA_WIDTH-1:0]   r_i_rdata;
   logic [DATA_WIDTH-1:0]   r_d_rdata;
   logic                    r_mem_read;
   logic                    r_mem_write;
   logic [ADDRESS_BITS-1:0] r_mem_addr;
   logic [DATA_WIDTH-1:0]   r_mem_wdata;

   logic w_any;
   logic w_gnt_d;
   logic w_dwr;
   logic w_wd_fire;

   // With both requesting, the port that did not win last time gets the grant
   assign w_any     = i_req | d_req;
   assign w_gnt_d   = d_req & (~i_req | (r_last == G_I));
   assign w_dwr     = w_gnt_d & d_we;
   assign w_wd_fire = r_wait_cnt == WCW'(TIMEOUT - 1);

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state        <= S_IDLE;
         r_last         <= G_D;
         r_gnt          <= G_I;
         r_we           <= 1'b0;
         r_wait_cnt     <= '0;
         r_i_cnt        <= '0;
         r_d_cnt        <= '0;
         r_stall_cycles <= '0;
         r_timeout_err  <= 1'b0;
         r_i_ack        <= 1'b0;
         r_d_ack        <= 1'b0;
         r_i_rdata      <= '0;
         r_d_rdata      <= '0;
         r_mem_read     <= 1'b0;
         r_mem_write    <= 1'b0;
         r_mem_addr     <= '0;
         r_mem_wdata    <= '0;
      end else begin
         r_i_ack <= 1'b0;
         r_d_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gnt       <= w_gnt_d;
                  r_last      <= w_gnt_d;
                  r_we        <= w_dwr;
                  r_mem_read  <= ~w_dwr;
                  r_mem_write <= w_dwr;
                  r_mem_addr  <= w_gnt_d ? d_addr : i_addr;
                  r_mem_wdata <= w_dwr ? d_wdata : '0;
                  r_wait_cnt  <= '0;
                  r_state     <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (m_stall) begin
                  r_wait_cnt     <= r_wait_cnt + 1'b1;
                  r_stall_cycles <= r_stall_cycles
                                    + {31'd0, ~&r_stall_cycles};
               end
               if (!m_stall || w_wd_fire) begin
                  if (m_stall) begin
                     r_timeout_err <= 1'b1;
                     if (r_gnt) r_d_rdata <= '0;
                     else       r_i_rdata <= '0;
                  end else if (!r_we) begin
                     if (r_gnt) r_d_rdata <= mem_rdata;
                     else       r_i_rdata <= mem_rdata;
                  end
                  if (r_gnt) r_d_cnt <= r_d_cnt + {31'd0, ~&r_d_cnt};
                  else       r_i_cnt <= r_i_cnt + {31'd0, ~&r_i_cnt};
                  r_i_ack     <= ~r_gnt;
                  r_d_ack     <= r_gnt;
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b0;
                  r_mem_addr  <= '0;
                  r_mem_wdata <= '0;
                  r_state     <= S_RESP;
               end
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign i_ack        = r_i_ack;
   assign d_ack        = r_d_ack;
   assign i_rdata      = r_i_rdata;
   assign d_rdata      = r_d_rdata;
   assign mem_read     = r_mem_read;
   assign mem_write    = r_mem_write;
   assign mem_addr     = r_mem_addr;
   assign mem_wdata    = r_mem_wdata;
   assign timeout_err  = r_timeout_err;
   assign stall_cycles = r_stall_cycles;

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (report)
         $display("core %0d: i_txn=%0d d_txn=%0d stall_cycles=%0d timeout_err=%0b",
                  CORE, r_i_cnt, r_d_cnt, r_stall_cycles, r_timeout_err);
   end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: randomized requesters and memory, transaction-level model.
// Expected requests and acks are queued by the stimulus and checked by a monitor.
module tb_mem_req_arbiter;

   localparam int T = 8;

   logic        clock, reset;
   logic        i_req, d_req, d_we;
   logic [19:0] i_addr, d_addr;
   logic [31:0] d_wdata, mem_rdata;
   logic        m_stall, report;
   logic        i_ack, d_ack, mem_read, mem_write, timeout_err;
   logic [31:0] i_rdata, d_rdata, mem_wdata, stall_cycles;
   logic [19:0] mem_addr;

   mem_req_arbiter #(
      .CORE(3), .DATA_WIDTH(32), .ADDRESS_BITS(20), .TIMEOUT(T)
   ) dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .m_stall(m_stall),
      .timeout_err(timeout_err), .stall_cycles(stall_cycles),
      .report(report)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int pe_cnt = 0;
   always @(posedge clock) pe_cnt <= pe_cnt + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s (t=%0t)", nm, $time);
   endtask

   typedef struct {
      bit          port;
      bit          we;
      logic [19:0] addr;
      logic [31:0] wdata;
      int          rise;
      int          fall;
   } mem_exp_t;

   typedef struct {
      bit          port;
      bit          chk_rd;
      logic [31:0] rdata;
      int          at;
      logic [31:0] stall;
      bit          terr;
   } ack_exp_t;

   mem_exp_t mem_q[$];
   ack_exp_t ack_q[$];

   // monitor
   bit       mon_en = 0;
   bit       prev_strb = 0;
   bit       have_m = 0;
   mem_exp_t cur_m;
   ack_exp_t cur_a;

   always @(negedge clock) begin
      if (mon_en) begin
         chk("ack_excl", {63'd0, i_ack & d_ack}, 0);
         chk("strobe_excl", {63'd0, mem_read & mem_write}, 0);
         if (mem_read | mem_write) begin
            if (!prev_strb) begin
               if (mem_q.size() == 0) begin
                  have_m = 0;
                  fail("unexpected_request");
               end else begin
                  cur_m  = mem_q.pop_front();
                  have_m = 1;
                  chk("req_start", pe_cnt, cur_m.rise);
               end
            end
            if (have_m) begin
               chk("mem_read", {63'd0, mem_read}, {63'd0, !cur_m.we});
               chk("mem_write", {63'd0, mem_write}, {63'd0, cur_m.we});
               chk("mem_addr", mem_addr, cur_m.addr);
               if (cur_m.we) chk("mem_wdata", mem_wdata, cur_m.wdata);
            end
         end else begin
            if (prev_strb && have_m) chk("req_end", pe_cnt, cur_m.fall);
            chk("idle_addr", mem_addr, 0);
            chk("idle_wdata", mem_wdata, 0);
         end
         prev_strb = mem_read | mem_write;
         if (i_ack | d_ack) begin
            if (ack_q.size() == 0) fail("unexpected_ack");
            else begin
               cur_a = ack_q.pop_front();
               chk("ack_port", {63'd0, d_ack}, {63'd0, cur_a.port});
               chk("ack_time", pe_cnt, cur_a.at);
               if (cur_a.chk_rd)
                  chk("rdata", cur_a.port ? d_rdata : i_rdata, cur_a.rdata);
               chk("stall_cycles", stall_cycles, cur_a.stall);
               chk("timeout_err", {63'd0, timeout_err}, {63'd0, cur_a.terr});
            end
         end
      end
   end

   // stimulus and transaction-level model
   bit          i_out, d_out, act, gport, gwe, last_d, m_terr;
   int          e0, n, s, next_samp;
   logic [31:0] m_stall_tot;

   task automatic step(input int p);
      int       t, j;
      bit       jd_i, jd_d, abort;
      mem_exp_t me;
      ack_exp_t ae;
      @(negedge clock);
      t = pe_cnt;
      jd_i = 0;
      jd_d = 0;
      mem_rdata = $urandom;
      m_stall = 1'($urandom_range(0, 1));
      if (act) begin
         j = t - e0;
         abort = s >= T;
         if (j >= 1 && j <= n) begin
            m_stall = j <= s;
            if ($urandom_range(0, 7) == 0) begin
               if (gport) d_req = 0;
               else       i_req = 0;
            end
            if (j == n) begin
               m_stall_tot += abort ? T : s;
               if (abort) m_terr = 1;
               ae.port   = gport;
               ae.chk_rd = !gwe || abort;
               ae.rdata  = abort ? 32'd0 : mem_rdata;
               ae.at     = t + 1;
               ae.stall  = m_stall_tot;
               ae.terr   = m_terr;
               ack_q.push_back(ae);
            end
         end
         if (j == n + 1) begin
            if (gport) begin d_req = 0; d_out = 0; jd_d = 1; end
            else       begin i_req = 0; i_out = 0; jd_i = 1; end
            act = 0;
         end
      end
      if (!i_out && !jd_i && $urandom_range(0, 99) < p) begin
         i_out  = 1;
         i_req  = 1;
         i_addr = 20'($urandom);
      end
      if (!d_out && !jd_d && $urandom_range(0, 99) < p) begin
         d_out   = 1;
         d_req   = 1;
         d_we    = 1'($urandom_range(0, 1));
         d_addr  = 20'($urandom);
         d_wdata = $urandom;
      end
      if (!act && t >= next_samp && (i_req || d_req)) begin
         gport = d_req && (!i_req || !last_d);
         last_d = gport;
         gwe = gport && d_we;
         j = $urandom_range(0, 15);
         if (j < 6)       s = 0;
         else if (j < 13) s = $urandom_range(1, 5);
         else             s = $urandom_range(T, T + 3);
         n = (s >= T) ? T : s + 1;
         e0 = t;
         act = 1;
         next_samp = t + n + 2;
         me.port  = gport;
         me.we    = gwe;
         me.addr  = gport ? d_addr : i_addr;
         me.wdata = d_wdata;
         me.rise  = t + 1;
         me.fall  = t + n + 1;
         mem_q.push_back(me);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_i_ack"}, {63'd0, i_ack}, 0);
      chk({tag, "_d_ack"}, {63'd0, d_ack}, 0);
      chk({tag, "_i_rdata"}, i_rdata, 0);
      chk({tag, "_d_rdata"}, d_rdata, 0);
      chk({tag, "_mem_read"}, {63'd0, mem_read}, 0);
      chk({tag, "_mem_write"}, {63'd0, mem_write}, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_timeout_err"}, {63'd0, timeout_err}, 0);
      chk({tag, "_stall_cycles"}, stall_cycles, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit");
   end

   initial begin
      reset = 0; i_req = 0; d_req = 0; d_we = 0; report = 0;
      i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0; m_stall = 0;
      repeat (3) @(negedge clock);
      chk_zero("reset");

      // single load, no stall
      reset = 1;
      d_req = 1; d_we = 0; d_addr = 20'h00010; mem_rdata = 32'hDEADBEEF;
      @(negedge clock);
      chk("t1_mem_read", {63'd0, mem_read}, 1);
      chk("t1_mem_addr", mem_addr, 20'h00010);
      @(negedge clock);
      chk("t1_d_ack", {63'd0, d_ack}, 1);
      chk("t1_d_rdata", d_rdata, 32'hDEADBEEF);
      chk("t1_i_ack", {63'd0, i_ack}, 0);
      d_req = 0;
      @(negedge clock);
      chk("t1_ack_len", {63'd0, d_ack}, 0);
      @(negedge clock);

      // reset while BUSY aborts the write
      d_req = 1; d_we = 1; d_addr = 20'h00F00; d_wdata = 32'h12345678;
      m_stall = 1;
      @(negedge clock);
      chk("t5_mem_write", {63'd0, mem_write}, 1);
      @(negedge clock);
      chk("t5_stall_cnt", stall_cycles, 1);
      reset = 0; d_req = 0;
      @(negedge clock);
      chk_zero("midrst");
      @(negedge clock);
      chk("t5_no_ack", {63'd0, d_ack}, 0);
      m_stall = 0;
      reset = 1;

      i_out = 0; d_out = 0; act = 0; last_d = 1; m_terr = 0;
      m_stall_tot = 0;
      next_samp = pe_cnt;
      mon_en = 1;
      for (int k = 0; k < 700; k++) step(30);
      for (int k = 0; k < 200; k++) step(100);
      for (int k = 0; k < 300 && (act || i_out || d_out); k++) step(0);
      if (act || i_out || d_out) fail("drain_timeout");
      repeat (3) step(0);

      chk("final_ack_q", ack_q.size(), 0);
      chk("final_mem_q", mem_q.size(), 0);
      chk("final_stall_cycles", stall_cycles, m_stall_tot);
      chk("final_timeout_err", {63'd0, timeout_err}, {63'd0, m_terr});
      report = 1;
      @(negedge clock);
      report = 0;
      @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
